// File: rtl/slink_nch_tx_sched.sv
// slink_nch_tx_sched: merges whole packets from CH_NUM show-ahead source FIFOs
// onto one SLINK_TX word port using packet-atomic round-robin arbitration.
// It polices framing and packet length, and keeps sticky per-channel error flags.
// Latency: a word popped in cycle t appears registered on tx_* in cycle t+1.
// Backpressure: pops in SEND only while tx_rdreq=1. FLUSH drains regardless of tx_rdreq.
// Ports:
//   clk_125m, rst_125m    clock, synchronous active-high reset
//   ch_en/ch_empty/ch_data  per-channel enable, empty flag, head word {sop,eop,payload}
//   ch_rdreq              one-hot-or-zero pop strobe to the granted source
//   tx_rdreq              downstream accepts a word this cycle
//   len_limit, err_clr    max words per packet (0 = off), clear all ch_err bits
//   tx_data/tx_dval/tx_chid/tx_eop  forwarded word, valid, source channel, end pulse
//   ch_err                sticky per-channel framing/length error flags
module slink_nch_tx_sched #(
  parameter int CH_NUM = 4,
  parameter int DW     = 16,
  parameter int LEN_W  = 16,
  parameter int CID_W  = 2
) (
  input  logic                       clk_125m,
  input  logic                       rst_125m,
  input  logic [CH_NUM-1:0]          ch_en,
  input  logic [CH_NUM-1:0]          ch_empty,
  input  logic [CH_NUM*(DW+2)-1:0]   ch_data,
  output logic [CH_NUM-1:0]          ch_rdreq,
  input  logic                       tx_rdreq,
  input  logic [LEN_W-1:0]           len_limit,
  input  logic                       err_clr,
  output logic [DW+1:0]              tx_data,
  output logic                       tx_dval,
  output logic [CID_W-1:0]           tx_chid,
  output logic                       tx_eop,
  output logic [CH_NUM-1:0]          ch_err
);
  localparam int WW = DW + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CID_W-1:0]  grant_q, grant_d;
  logic [CID_W-1:0]  last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]     tx_data_q, tx_data_d;
  logic              tx_dval_q, tx_dval_d;
  logic [CID_W-1:0]  tx_chid_q, tx_chid_d;
  logic              tx_eop_q, tx_eop_d;
  logic [CH_NUM-1:0] ch_err_q, ch_err_d;

  // Head word and empty flag of the granted channel.
  logic [WW-1:0]     head_w;
  logic              head_empty;
  logic [CH_NUM-1:0] grant_oh;

  always_comb begin
    head_w     = '0;
    head_empty = 1'b1;
    grant_oh   = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (grant_q == CID_W'(c)) begin
        head_w      = ch_data[c*WW +: WW];
        head_empty  = ch_empty[c];
        grant_oh[c] = 1'b1;
      end
    end
  end

  // Cyclic search starting after last_grant. Scanning k downwards and letting
  // later hits overwrite earlier ones leaves the nearest eligible channel.
  logic [CH_NUM-1:0] eligible;
  logic              arb_found;
  logic [CID_W-1:0]  arb_ch;

  always_comb begin
    eligible  = ch_en & ~ch_empty;
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int k = CH_NUM; k >= 1; k--) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (eligible[c] && (c == (int'(last_grant_q) + k) % CH_NUM)) begin
          arb_found = 1'b1;
          arb_ch    = CID_W'(c);
        end
      end
    end
  end

  // The pop is combinational from registered state. It is forced low during reset.
  logic pop;

  always_comb begin
    pop = 1'b0;
    if (!rst_125m && !head_empty) begin
      if (state_q == ST_SEND)       pop = tx_rdreq;
      else if (state_q == ST_FLUSH) pop = 1'b1;
    end
    ch_rdreq = pop ? grant_oh : '0;
  end

  logic              w_sop, w_eop;
  logic [LEN_W:0]    cnt_inc;
  logic [CH_NUM-1:0] err_set;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_dval_d    = 1'b0;
    tx_chid_d    = tx_chid_q;
    tx_eop_d     = 1'b0;
    err_set      = '0;
    w_sop        = head_w[WW-1];
    w_eop        = head_w[WW-2];
    // One bit wider, so a saturated counter can never alias onto len_limit.
    cnt_inc      = {1'b0, cnt_q} + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_ch;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pop) begin
          if (cnt_q == '0 && !w_sop) begin
            // A stray word before a start of packet is dropped. cnt is untouched.
            err_set = grant_oh;
          end else begin
            tx_data_d = head_w;
            tx_dval_d = 1'b1;
            tx_chid_d = grant_q;
            if (cnt_q != {LEN_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (w_eop) begin
              tx_eop_d     = 1'b1;
              last_grant_d = grant_q;
              state_d      = ST_IDLE;
            end else if (len_limit != '0 && cnt_inc == {1'b0, len_limit}) begin
              // Truncate: close the packet downstream, then drain the rest of it.
              tx_data_d[WW-2] = 1'b1;
              tx_eop_d        = 1'b1;
              err_set         = grant_oh;
              last_grant_d    = grant_q;
              state_d         = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (pop && w_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new error beats a simultaneous clear.
    ch_err_d = (err_clr ? '0 : ch_err_q) | err_set;
  end

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CID_W'(CH_NUM - 1);
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_dval_q    <= 1'b0;
      tx_chid_q    <= '0;
      tx_eop_q     <= 1'b0;
      ch_err_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_dval_q    <= tx_dval_d;
      tx_chid_q    <= tx_chid_d;
      tx_eop_q     <= tx_eop_d;
      ch_err_q     <= ch_err_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_dval = tx_dval_q;
  assign tx_chid = tx_chid_q;
  assign tx_eop  = tx_eop_q;
  assign ch_err  = ch_err_q;

endmodule

// File: tb/tb_slink_nch_tx_sched.sv
// Bench for slink_nch_tx_sched: FIFO models feed the DUT; a packet-level
// reference predicts the forwarded word stream and errors.
// Directed cases pin the reference. Randomized phases exercise it broadly.
module tb_slink_nch_tx_sched;
  localparam int CH_NUM = 4;
  localparam int DW     = 16;
  localparam int LEN_W  = 16;
  localparam int CID_W  = 2;
  localparam int WW     = DW + 2;

  typedef struct packed {
    logic [WW-1:0]    w;
    logic [CID_W-1:0] ch;
    logic             eop;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic [CH_NUM-1:0]        ch_en;
  logic [CH_NUM-1:0]        ch_empty;
  logic [CH_NUM*WW-1:0]     ch_data;
  logic [CH_NUM-1:0]        ch_rdreq;
  logic                     tx_rdreq;
  logic [LEN_W-1:0]         len_limit;
  logic                     err_clr;
  logic [WW-1:0]            tx_data;
  logic                     tx_dval;
  logic [CID_W-1:0]         tx_chid;
  logic                     tx_eop;
  logic [CH_NUM-1:0]        ch_err;

  slink_nch_tx_sched #(.CH_NUM(CH_NUM), .DW(DW), .LEN_W(LEN_W), .CID_W(CID_W)) dut (
    .clk_125m(clk), .rst_125m(rst), .ch_en(ch_en), .ch_empty(ch_empty),
    .ch_data(ch_data), .ch_rdreq(ch_rdreq), .tx_rdreq(tx_rdreq),
    .len_limit(len_limit), .err_clr(err_clr), .tx_data(tx_data),
    .tx_dval(tx_dval), .tx_chid(tx_chid), .tx_eop(tx_eop), .ch_err(ch_err)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Source FIFO contents, reference state and logs.
  logic [WW-1:0]     srcq [CH_NUM][$];
  exp_t              exp_q [$];
  logic [CH_NUM-1:0] exp_err;
  int                mdl_last;
  int                n_cmp, n_fail;
  int                rd_mode;   // 0: always 1, 1: toggle, 2: random
  bit                hide_en;
  logic [CH_NUM-1:0] hide;
  logic [CH_NUM-1:0] pend_pop;
  logic              last_rdreq;
  bit                use_model, gap_chk, have_eop;
  int                cyc, last_eop_cyc;
  int                dval_cnt, eop_cnt;
  logic [WW-1:0]     log_w [$];
  int                log_ch [$];
  int                eop_ch [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < CH_NUM; c++) begin
      ch_empty[c] = hide[c] || (srcq[c].size() == 0);
      ch_data[c*WW +: WW] = (srcq[c].size() > 0) ? srcq[c][0] : '0;
    end
  endtask

  task automatic clear_logs();
    dval_cnt = 0; eop_cnt = 0; have_eop = 0;
    log_w.delete(); log_ch.delete(); eop_ch.delete();
  endtask

  task automatic push_pkt(input int c, input int len);
    for (int k = 0; k < len; k++)
      srcq[c].push_back({k == 0, k == len - 1, DW'($urandom)});
  endtask

  task automatic push_stray(input int c);
    srcq[c].push_back({2'b00, DW'($urandom)});
  endtask

  // One clock: apply the pops observed before the edge, then drive the next inputs.
  task automatic step();
    logic [WW-1:0] junk;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH_NUM; c++) begin
      if (pend_pop[c]) begin
        chk("pop_nonempty", srcq[c].size() > 0, 1);
        if (srcq[c].size() > 0) junk = srcq[c].pop_front();
      end
    end
    pend_pop = '0;
    case (rd_mode)
      0:       tx_rdreq = 1'b1;
      1:       tx_rdreq = ~tx_rdreq;
      default: tx_rdreq = ($urandom_range(0, 3) != 0);
    endcase
    hide = hide_en ? CH_NUM'($urandom) : '0;
    refresh();
  endtask

  // Packet-level reference: walk the queued packets in round-robin order and
  // list every word that must leave the port, plus which channels must flag.
  task automatic model_build();
    logic [WW-1:0] cq [CH_NUM][$];
    logic [WW-1:0] w;
    int  c, cnt;
    bit  more, done, fl;
    exp_q.delete();
    for (int i = 0; i < CH_NUM; i++) cq[i] = srcq[i];
    more = 1;
    while (more) begin
      c = -1;
      for (int k = 1; k <= CH_NUM; k++)
        if (c < 0 && ch_en[(mdl_last + k) % CH_NUM] && cq[(mdl_last + k) % CH_NUM].size() > 0)
          c = (mdl_last + k) % CH_NUM;
      if (c < 0) more = 0;
      else begin
        cnt = 0; done = 0;
        while (!done && cq[c].size() > 0) begin
          w = cq[c].pop_front();
          if (cnt == 0 && !w[WW-1]) exp_err[c] = 1'b1;
          else if (w[WW-2]) begin
            exp_q.push_back('{w: w, ch: CID_W'(c), eop: 1'b1});
            done = 1;
          end else if (len_limit != 0 && cnt + 1 == int'(len_limit)) begin
            w[WW-2] = 1'b1;
            exp_q.push_back('{w: w, ch: CID_W'(c), eop: 1'b1});
            exp_err[c] = 1'b1;
            fl = 1;
            while (fl && cq[c].size() > 0) begin
              w = cq[c].pop_front();
              if (w[WW-2]) fl = 0;
            end
            done = 1;
          end else begin
            exp_q.push_back('{w: w, ch: CID_W'(c), eop: 1'b0});
            cnt++;
          end
        end
        mdl_last = c;
      end
    end
  endtask

  function automatic bit busy();
    busy = 0;
    for (int c = 0; c < CH_NUM; c++) if (ch_en[c] && srcq[c].size() > 0) busy = 1;
  endfunction

  task automatic run_phase(input string name, input int budget);
    int n;
    clear_logs();
    model_build();
    n = 0;
    while ((exp_q.size() > 0 || busy()) && n < budget) begin step(); n++; end
    if (n >= budget) chk({name, "_timeout"}, 1, 0);
    repeat (4) step();
    chk({name, "_exp_drained"}, exp_q.size(), 0);
    chk({name, "_ch_err"}, ch_err, exp_err);
    exp_q.delete();
  endtask

  task automatic step_until_dval(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (dval_cnt < n && k < budget) begin step(); k++; end
    if (dval_cnt < n) chk({name, "_timeout"}, dval_cnt, n);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err = '0;
    chk("err_clr", ch_err, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    mdl_last = CH_NUM - 1;
    exp_err  = '0;
  endtask

  // Compare process: checks the registered outputs every cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rdreq_in_reset", ch_rdreq, 0);
      end else begin
        chk("rdreq_onehot0", $onehot0(ch_rdreq), 1);
        if (tx_eop) chk("eop_without_dval", tx_dval, 1);
        if (tx_dval) begin
          chk("dval_after_rdreq_low", last_rdreq, 1);
          dval_cnt++;
          log_w.push_back(tx_data);
          log_ch.push_back(int'(tx_chid));
          if (tx_eop) begin eop_cnt++; eop_ch.push_back(int'(tx_chid)); end
          if (gap_chk && have_eop && tx_data[WW-1]) chk("idle_gap", cyc - last_eop_cyc, 2);
          if (use_model) begin
            if (exp_q.size() == 0) chk("unexpected_word", tx_data, 0);
            else begin
              e = exp_q.pop_front();
              chk("tx_data", tx_data, e.w);
              chk("tx_chid", tx_chid, e.ch);
              chk("tx_eop", tx_eop, e.eop);
            end
          end
          if (tx_eop) begin have_eop = 1; last_eop_cyc = cyc; end
        end
        if (use_model) chk("err_not_expected", ch_err & ~exp_err, 0);
      end
      last_rdreq = tx_rdreq;
      pend_pop   = ch_rdreq;
    end
  end

  initial begin
    int rr_exp [8];
    rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    n_cmp = 0; n_fail = 0; cyc = 0; last_eop_cyc = 0;
    rst = 1'b1; ch_en = '1; tx_rdreq = 1'b1; len_limit = '0; err_clr = 1'b0;
    rd_mode = 0; hide_en = 0; hide = '0; pend_pop = '0; last_rdreq = 1'b0;
    use_model = 1; gap_chk = 0; exp_err = '0; mdl_last = CH_NUM - 1;
    ch_empty = '1; ch_data = '0;
    clear_logs();
    refresh();

    // Reset values.
    do_reset(3);
    rst = 1'b1;
    chk("rst_tx_dval", tx_dval, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_chid", tx_chid, 0);
    chk("rst_tx_eop", tx_eop, 0);
    chk("rst_ch_err", ch_err, 0);
    chk("rst_ch_rdreq", ch_rdreq, 0);
    rst = 1'b0;

    // Round-robin: two 3-word packets per channel, tx_rdreq held high.
    for (int r = 0; r < 2; r++) for (int c = 0; c < CH_NUM; c++) push_pkt(c, 3);
    refresh();
    gap_chk = 1; rd_mode = 0;
    run_phase("rr", 400);
    gap_chk = 0;
    chk("rr_words", dval_cnt, 24);
    chk("rr_pkts", eop_ch.size(), 8);
    for (int i = 0; i < 8; i++) if (i < eop_ch.size()) chk("rr_order", eop_ch[i], rr_exp[i]);

    // Backpressure: one 5-word packet on ch2, tx_rdreq toggling.
    push_pkt(2, 5);
    refresh();
    rd_mode = 1;
    run_phase("bp", 400);
    chk("bp_words", dval_cnt, 5);
    chk("bp_eops", eop_cnt, 1);
    if (log_w.size() == 5) begin
      chk("bp_w4_not_eop", log_w[3][WW-2], 0);
      chk("bp_w5_eop", log_w[4][WW-2], 1);
    end
    chk("bp_ch_err", ch_err, 0);

    // Length abort: limit 4, a 10-word packet then a 2-word packet on ch1.
    rd_mode = 0; len_limit = 16'd4;
    push_pkt(1, 10); push_pkt(1, 2);
    refresh();
    run_phase("abort", 400);
    chk("abort_words", dval_cnt, 6);
    chk("abort_eops", eop_cnt, 2);
    if (log_w.size() == 6) chk("abort_w4_eop_bit", log_w[3][WW-2], 1);
    chk("abort_ch_err", ch_err, 4'b0010);
    chk("abort_drained", srcq[1].size(), 0);
    len_limit = '0;
    clear_errors();

    // Framing: stray word on ch3, then a valid 2-word packet.
    push_stray(3); push_pkt(3, 2);
    refresh();
    run_phase("frame", 400);
    chk("frame_words", dval_cnt, 2);
    chk("frame_ch_err", ch_err, 4'b1000);
    clear_errors();

    // Disable mid-packet: ch0 finishes its packet and is then skipped.
    use_model = 0;
    clear_logs();
    push_pkt(0, 4); push_pkt(0, 2); push_pkt(1, 2);
    refresh();
    step_until_dval(1, 50, "dis_start");
    ch_en = 4'b1110;
    step_until_dval(6, 100, "dis_rest");
    repeat (10) step();
    chk("dis_words", dval_cnt, 6);
    for (int i = 0; i < 6; i++) if (i < log_ch.size()) chk("dis_chid", log_ch[i], (i < 4) ? 0 : 1);
    chk("dis_ch0_left", srcq[0].size(), 2);

    // Reset mid-packet: outputs return to reset values, ch0 wins first afterwards.
    ch_en = '1;
    clear_logs();
    push_pkt(2, 6);
    refresh();
    step_until_dval(2, 50, "rstmid_start");
    if (log_ch.size() > 0) chk("rstmid_first_ch2", log_ch[0], 2);
    rst = 1'b1;
    srcq[2].delete();
    push_pkt(1, 2);
    refresh();
    #1;
    chk("rstmid_rdreq_comb", ch_rdreq, 0);
    step();
    chk("rstmid_tx_dval", tx_dval, 0);
    chk("rstmid_tx_data", tx_data, 0);
    chk("rstmid_tx_chid", tx_chid, 0);
    chk("rstmid_tx_eop", tx_eop, 0);
    chk("rstmid_ch_err", ch_err, 0);
    do_reset(1);
    clear_logs();
    step_until_dval(1, 50, "rstmid_after");
    if (log_ch.size() > 0) chk("rstmid_ch0_first", log_ch[0], 0);
    step_until_dval(4, 50, "rstmid_drain");
    repeat (4) step();
    chk("rstmid_drained", srcq[0].size() + srcq[1].size(), 0);

    // Randomized phases against the reference.
    do_reset(2);
    use_model = 1;
    for (int it = 0; it < 6; it++) begin
      int sc;
      case ($urandom_range(0, 4))
        0, 1:    len_limit = '0;
        2:       len_limit = 16'd3;
        3:       len_limit = 16'd5;
        default: len_limit = 16'd7;
      endcase
      ch_en = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
      for (int c = 0; c < CH_NUM; c++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          if ($urandom_range(0, 4) == 0) push_stray(c);
          push_pkt(c, $urandom_range(1, 8));
        end
      end
      refresh();
      rd_mode = 2; hide_en = 0;
      run_phase("rand_multi", 3000);
      clear_errors();

      // Single enabled channel with the source running dry at random.
      sc = $urandom_range(0, CH_NUM - 1);
      ch_en = '0;
      ch_en[sc] = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 3) == 0) push_stray(sc);
        push_pkt(sc, $urandom_range(1, 9));
      end
      hide_en = 1;
      refresh();
      run_phase("rand_stall", 3000);
      hide_en = 0;
      clear_errors();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
